// File: rtl/freq_counter_pkg.sv
// ---------------------------------------------------------------------------
// freq_counter_pkg
//   Shared constants and types for the BCD frequency counter.
//   - DEFAULT_NUM_DIGITS : default number of BCD digits in count and result
//   - BCD_DIGIT_W        : width of one BCD digit
//   - BCD_MAX_DIGIT      : largest legal BCD digit value (9)
//   - state_e            : measurement state machine encoding
//   - is_max_digit()     : true when a digit sits at its wrap point
// ---------------------------------------------------------------------------
package freq_counter_pkg;

    localparam int         DEFAULT_NUM_DIGITS = 8;
    localparam int         BCD_DIGIT_W        = 4;
    localparam logic [3:0] BCD_MAX_DIGIT      = 4'd9;

    // ARM     : waiting for the first gate edge, count held at zero
    // MEASURE : a window is open; every gate edge closes it and opens the next
    typedef enum logic [0:0] {
        ST_ARM     = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

    function automatic logic is_max_digit(input logic [BCD_DIGIT_W-1:0] d);
        return d == BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/freq_counter_if.sv
// ---------------------------------------------------------------------------
// freq_counter_if
//   Groups the measurement inputs and the result bus of freq_counter.
//   Signals:
//     Gate_1Hz   : gate square wave, one window = rising edge to rising edge
//     Sig_In     : measured signal (asynchronous to the system clock)
//     Freq_BCD   : latched packed-BCD result, digit 0 in bits [3:0]
//     Data_Valid : result-update strobe
//     Overflow   : latched together with Freq_BCD
//   Modports:
//     master : the counter (consumes gate/signal, produces the result)
//     slave  : whoever drives the gate/signal and consumes the result
//
//   Result handshake: Data_Valid is a valid-only strobe with no ready/back-
//   pressure. It is high for exactly one clock cycle, during which Freq_BCD
//   and Overflow already carry the new result; both stay stable until the
//   next Data_Valid pulse (or reset), so a consumer may also sample them late.
// ---------------------------------------------------------------------------
interface freq_counter_if
    import freq_counter_pkg::*;
#(
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
) ();

    logic                              Gate_1Hz;
    logic                              Sig_In;
    logic [BCD_DIGIT_W*NUM_DIGITS-1:0] Freq_BCD;
    logic                              Data_Valid;
    logic                              Overflow;

    modport master (
        input  Gate_1Hz,
        input  Sig_In,
        output Freq_BCD,
        output Data_Valid,
        output Overflow
    );

    modport slave (
        output Gate_1Hz,
        output Sig_In,
        input  Freq_BCD,
        input  Data_Valid,
        input  Overflow
    );

endinterface

// File: rtl/freq_counter_bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
//   One decade of the working count: a 4-bit BCD counter 0..9.
//   Ports:
//     i_clk   : system clock
//     i_rst   : synchronous active-high reset (digit -> 0)
//     i_clr   : synchronous clear (digit -> 0), beats load and enable
//     i_load1 : synchronous load of 1, beats enable
//     i_en    : count enable / carry in from the lower digit
//     o_digit : current digit value, never above 9
//     o_carry : high when this digit wraps 9 -> 0 this cycle; feeds the next
//               digit's i_en combinationally so the carry lands in the same
//               cycle as the wrap
// ---------------------------------------------------------------------------
module bcd_digit
    import freq_counter_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_load1,
    input  logic                   i_en,
    output logic [BCD_DIGIT_W-1:0] o_digit,
    output logic                   o_carry
);

    logic [BCD_DIGIT_W-1:0] r_digit;
    logic                   w_at_max;

    assign w_at_max = is_max_digit(r_digit);
    assign o_carry  = i_en & w_at_max;
    assign o_digit  = r_digit;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_digit <= '0;
        end else if (i_load1) begin
            r_digit <= 4'd1;
        end else if (i_en) begin
            r_digit <= w_at_max ? 4'd0 : r_digit + 4'd1;
        end
    end

endmodule

// File: rtl/freq_counter.sv
// ---------------------------------------------------------------------------
// freq_counter
//   Gated BCD frequency counter. Counts rising edges of Sig_In over one full
//   period of Gate_1Hz and publishes the count as packed BCD at every gate
//   rising edge. The count saturates at all-9s and flags Overflow.
//   Ports:
//     CLK_50M     : system clock, the only clock
//     CLR         : synchronous active-high reset
//     io_bus      : freq_counter_if.master (Gate_1Hz, Sig_In in;
//                   Freq_BCD, Data_Valid, Overflow out)
//     o_dbg_state : current measurement state (ARM / MEASURE)
//   Timing:
//     A Sig_In rising edge first sampled high at edge A increments the
//     working count at edge A+3 (2 synchroniser flops, edge detect, one
//     registered rise pulse). Data_Valid and the new Freq_BCD appear in the
//     cycle after the gate edge that closes the window.
// ---------------------------------------------------------------------------
module freq_counter
    import freq_counter_pkg::*;
#(
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
) (
    input  logic                  CLK_50M,
    input  logic                  CLR,
    freq_counter_if.master        io_bus,
    output state_e                o_dbg_state
);

    localparam int W = BCD_DIGIT_W * NUM_DIGITS;

    // Sig_In synchroniser and edge detector
    logic r_sig_s1;
    logic r_sig_s2;
    logic r_sig_s3;
    logic r_sig_rise;

    // Gate edge detector
    logic r_gate_d;
    logic w_gate_edge;

    // State machine
    state_e r_state;
    state_e w_state_next;
    logic   w_hold_zero;
    logic   w_latch;

    // Working count
    logic [W-1:0] w_count;
    logic         w_inc;
    logic         w_all9;
    logic         w_restart;
    logic         w_inc_run;
    logic         w_clr_lsd;
    logic         w_load1_lsd;
    logic         w_clr_upper;
    logic         w_top_carry;
    logic         r_ovf_flag;

    // Published result
    logic [W-1:0] r_freq;
    logic         r_ovf;
    logic         r_dv;

    // -----------------------------------------------------------------------
    // Sig_In: two flops for metastability, a third as the delayed copy for
    // edge detection, and the detected rise registered once more so the
    // increment lands exactly three edges after the first high sample.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_50M) begin
        if (CLR) begin
            r_sig_s1   <= 1'b0;
            r_sig_s2   <= 1'b0;
            r_sig_s3   <= 1'b0;
            r_sig_rise <= 1'b0;
        end else begin
            r_sig_s1   <= io_bus.Sig_In;
            r_sig_s2   <= r_sig_s1;
            r_sig_s3   <= r_sig_s2;
            r_sig_rise <= r_sig_s2 & ~r_sig_s3;
        end
    end

    assign w_inc = r_sig_rise;

    // -----------------------------------------------------------------------
    // Gate_1Hz is already synchronous; one history flop is enough. The edge
    // is acted on at the very clock edge that first samples the gate high.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_50M) begin
        if (CLR) begin
            r_gate_d <= 1'b0;
        end else begin
            r_gate_d <= io_bus.Gate_1Hz;
        end
    end

    assign w_gate_edge = io_bus.Gate_1Hz & ~r_gate_d;

    // -----------------------------------------------------------------------
    // State machine: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_50M) begin
        if (CLR) begin
            r_state <= ST_ARM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // State machine: next state. Every gate edge (re)opens a window.
    always_comb begin
        w_state_next = r_state;
        if (w_gate_edge) begin
            w_state_next = ST_MEASURE;
        end
    end

    // State machine: outputs. In ARM the first gate edge only opens a
    // window; the partial window before it is never published.
    always_comb begin
        w_hold_zero = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_ARM:     w_hold_zero = ~w_gate_edge;
            ST_MEASURE: w_latch     = w_gate_edge;
            default:    ;
        endcase
    end

    assign o_dbg_state = r_state;

    // -----------------------------------------------------------------------
    // Working count control
    // -----------------------------------------------------------------------
    always_comb begin
        w_all9 = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!is_max_digit(w_count[BCD_DIGIT_W*i +: BCD_DIGIT_W])) begin
                w_all9 = 1'b0;
            end
        end
    end

    assign w_restart   = w_gate_edge;
    // An increment coincident with a gate edge belongs to the new window and
    // is absorbed by the load-1 below, so it is removed from the ripple path.
    // At all-9s the increment is dropped entirely, which is the saturation.
    assign w_inc_run   = w_inc & ~w_restart & ~w_hold_zero & ~w_all9;
    assign w_clr_lsd   = w_hold_zero | (w_restart & ~w_inc);
    assign w_load1_lsd = w_restart & w_inc;
    assign w_clr_upper = w_hold_zero | w_restart;

    // Cascaded decades; each digit's enable is the carry of the one below.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic w_en_in;
        logic w_carry_out;

        if (gi == 0) begin : g_lsd
            assign w_en_in = w_inc_run;
        end else begin : g_upper
            assign w_en_in = g_digit[gi-1].w_carry_out;
        end

        bcd_digit u_digit (
            .i_clk   (CLK_50M),
            .i_rst   (CLR),
            .i_clr   ((gi == 0) ? w_clr_lsd : w_clr_upper),
            .i_load1 ((gi == 0) ? w_load1_lsd : 1'b0),
            .i_en    (w_en_in),
            .o_digit (w_count[BCD_DIGIT_W*gi +: BCD_DIGIT_W]),
            .o_carry (w_carry_out)
        );
    end

    assign w_top_carry = g_digit[NUM_DIGITS-1].w_carry_out;

    // Saturation masks the increment at all-9s, so the top decade can never
    // ripple out; a carry here would mean the count silently wrapped.
    a_no_wrap : assert property (@(posedge CLK_50M) disable iff (CLR) !w_top_carry);

    // Sticky overflow for the current window; cleared when a window opens.
    always_ff @(posedge CLK_50M) begin
        if (CLR) begin
            r_ovf_flag <= 1'b0;
        end else if (w_hold_zero || w_restart) begin
            r_ovf_flag <= 1'b0;
        end else if (w_inc && w_all9) begin
            r_ovf_flag <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Result latch. The count captured is the value before this edge's
    // increment, which already belongs to the next window.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_50M) begin
        if (CLR) begin
            r_freq <= '0;
            r_ovf  <= 1'b0;
            r_dv   <= 1'b0;
        end else begin
            r_dv <= w_latch;
            if (w_latch) begin
                r_freq <= w_count;
                r_ovf  <= r_ovf_flag;
            end
        end
    end

    assign io_bus.Freq_BCD   = r_freq;
    assign io_bus.Overflow   = r_ovf;
    assign io_bus.Data_Valid = r_dv;

endmodule
